// File: rtl/wb_host_master.sv
// Wishbone classic initiator: turns a command handshake into single or incrementing
// multi-beat bus cycles and returns read data / completion status on a response handshake.
module wb_host_master #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    input  logic [3:0]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned LW = 4;
    localparam int unsigned TW = 16;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e         state_q;
    logic           cmd_ready_q;
    logic           busy_q;
    logic           cyc_q;
    logic           we_q;
    logic [SW-1:0]  sel_q;
    logic [AW-1:0]  adr_q;
    logic [AW-1:0]  adr_d;
    logic [DW-1:0]  dat_q;
    logic [LW-1:0]  len_q;
    logic [LW-1:0]  beat_q;
    logic [LW-1:0]  beat_d;
    logic [TW-1:0]  tmo_q;
    logic [TW-1:0]  tmo_d;
    logic           rsp_valid_q;
    logic [DW-1:0]  rsp_dat_q;
    logic           rsp_err_q;
    logic           rsp_last_q;
    logic           last_beat;

    assign tmo_d     = tmo_q + TW'(1);
    assign beat_d    = beat_q + LW'(1);
    assign adr_d     = adr_q + AW'(ADDR_STEP);
    assign last_beat = (beat_q == len_q);

    // Single-process FSM; every output below comes straight from a flop.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        state_q     <= BUS;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cyc_q       <= 1'b1;
                        we_q        <= cmd_we;
                        sel_q       <= cmd_sel;
                        adr_q       <= cmd_adr;
                        dat_q       <= cmd_dat;
                        len_q       <= cmd_len;
                        beat_q      <= '0;
                        tmo_q       <= '0;
                    end
                end
                BUS: begin
                    if (wbm_ack_i) begin
                        cyc_q <= 1'b0;
                        tmo_q <= '0;
                        if (!we_q) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_dat_q   <= wbm_dat_i;
                            rsp_err_q   <= 1'b0;
                            rsp_last_q  <= last_beat;
                        end else if (!last_beat) begin
                            state_q <= GAP;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_dat_q   <= '0;
                            rsp_err_q   <= 1'b0;
                            rsp_last_q  <= 1'b1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Abort: remaining beats of this command are abandoned.
                        state_q     <= RESP;
                        cyc_q       <= 1'b0;
                        tmo_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_dat_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_last_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                GAP: begin
                    state_q <= BUS;
                    cyc_q   <= 1'b1;
                    adr_q   <= adr_d;
                    beat_q  <= beat_d;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_last_q) begin
                            state_q     <= IDLE;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            we_q        <= 1'b0;
                            sel_q       <= '0;
                            adr_q       <= '0;
                            dat_q       <= '0;
                            rsp_err_q   <= 1'b0;
                            rsp_last_q  <= 1'b0;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Bench for wb_host_master: a Wishbone slave model with programmable ack latency,
// bus/response monitors, directed scenarios and randomized commands vs a transaction model.
module tb_wb_host_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel, cmd_len;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic        rsp_err, rsp_last, busy;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = 32'h0;
    logic        ack = 1'b0;

    wb_host_master #(.TIMEOUT(8), .ADDR_STEP(4)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
    } beat_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        last;
    } rsp_t;

    int n_cmp = 0;
    int n_fail = 0;

    // Stimulus controls, written only by the test tasks.
    int          ack_dly = 1;
    bit          no_ack = 1'b0;
    bit          rr_random = 1'b0;
    int          stall_at = -1;
    int          stall_until = 0;
    bit          rd_mode = 1'b0;
    int          rd_base = 0;
    logic [31:0] rd_seq [4];

    // Observations, written only by the slave/monitor processes.
    beat_t       beats[$];
    rsp_t        resps[$];
    int          windows[$];
    int          hs_cycles[$];
    int          acc_cycles[$];
    int          rdy_rise[$];
    logic [31:0] stall_dats[$];
    int          stall_bus = 0;
    int          stall_taken = 0;
    int          rd_cnt = 0;
    int          s_cnt = 0;
    int          cyc_cnt = 0;
    int          win_len = 0;
    int          cs_bad = 0;
    bit          prev_ready = 1'b0;
    beat_t       s_beat;
    rsp_t        m_rsp;

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
    endfunction

    function automatic rsp_t mk_rsp(input logic [31:0] d, input logic e, input logic l);
        rsp_t r;
        r.dat = d; r.err = e; r.last = l;
        return r;
    endfunction

    function automatic beat_t mk_beat(input logic [31:0] a, input logic w,
                                      input logic [31:0] d, input logic [3:0] s);
        beat_t b;
        b.adr = a; b.we = w; b.dat = d; b.sel = s;
        return b;
    endfunction

    // Slave model and response-ready driver, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (cyc && stb) begin
            s_cnt = s_cnt + 1;
            if (!no_ack && s_cnt == ack_dly) begin
                ack = 1'b1;
                s_beat = mk_beat(adr, we, dat_o, sel);
                beats.push_back(s_beat);
                if (we) begin
                    dat_i = $urandom;
                end else begin
                    if (rd_mode && (rd_cnt - rd_base) < 4) dat_i = rd_seq[rd_cnt - rd_base];
                    else dat_i = slv_data(adr);
                    rd_cnt = rd_cnt + 1;
                end
            end else begin
                ack = 1'b0;
            end
        end else begin
            s_cnt = 0;
            ack = 1'b0;
        end
        if (rsp_valid && resps.size() == stall_at && stall_taken < stall_until) begin
            rsp_ready = 1'b0;
            stall_taken = stall_taken + 1;
        end else if (rr_random) begin
            rsp_ready = 1'($urandom_range(0, 1));
        end else begin
            rsp_ready = 1'b1;
        end
    end

    // Monitor on the falling edge: bus windows, handshakes that complete at the next rise.
    always @(negedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (cyc) begin
            win_len = win_len + 1;
        end else if (win_len > 0) begin
            windows.push_back(win_len);
            win_len = 0;
        end
        if (cyc !== stb) cs_bad = cs_bad + 1;
        if (rsp_valid && rsp_ready) begin
            m_rsp = mk_rsp(rsp_dat, rsp_err, rsp_last);
            resps.push_back(m_rsp);
            hs_cycles.push_back(cyc_cnt);
        end
        if (rsp_valid && !rsp_ready) begin
            stall_dats.push_back(rsp_dat);
            if (cyc) stall_bus = stall_bus + 1;
        end
        if (cmd_valid && cmd_ready) acc_cycles.push_back(cyc_cnt);
        if (cmd_ready && !prev_ready) rdy_rise.push_back(cyc_cnt);
        prev_ready = cmd_ready;
    end

    task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [3:0] l, input string tag);
        bit ok = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_len = l;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_accept: cmd_ready never seen, expected accept within 200 cycles", tag);
        end
    endtask

    task automatic wait_last(input int r0, input int need, input string tag);
        bit done = 1'b0;
        int got;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk); #1;
            got = 0;
            for (int k = r0; k < resps.size(); k++) if (resps[k].last) got++;
            if (got >= need) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_done: final response missing, expected %0d within 3000 cycles", tag, need);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cyc, stb, we, sel, adr, dat_o} !== {1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_bus: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, expected all 0",
                     cyc, stb, we, sel, adr, dat_o);
        end
        n_cmp++;
        if ({cmd_ready, busy, rsp_valid, rsp_err, rsp_last, rsp_dat} !== {5'b10000, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_hs: got rdy=%b busy=%b rv=%b err=%b last=%b dat=%h, expected rdy=1 rest 0",
                     cmd_ready, busy, rsp_valid, rsp_err, rsp_last, rsp_dat);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy, cyc} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: got rdy/busy/cyc=%b, expected 100", {cmd_ready, busy, cyc});
        end
    endtask

    task automatic test_single_read();
        int r0 = resps.size();
        int w0 = windows.size();
        int q0 = rdy_rise.size();
        ack_dly = 2;
        rd_seq[0] = 32'h0000_002A;
        rd_base = rd_cnt;
        rd_mode = 1'b1;
        issue_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 4'd0, "sread");
        wait_last(r0, 1, "sread");
        rd_mode = 1'b0;
        n_cmp++;
        if (windows.size() - w0 != 1 || windows[w0] != 2) begin
            n_fail++;
            $display("FAIL sread_window: got %0d windows first len %0d, expected 1 window of 2",
                     windows.size() - w0, windows[w0]);
        end
        n_cmp++;
        if (resps.size() - r0 != 1 || resps[r0] !== mk_rsp(32'h2A, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL sread_rsp: got %0d rsps first %h, expected 1 rsp %h",
                     resps.size() - r0, resps[r0], mk_rsp(32'h2A, 1'b0, 1'b1));
        end
        n_cmp++;
        if (rdy_rise.size() <= q0 || rdy_rise[q0] - hs_cycles[r0] < 1 || rdy_rise[q0] - hs_cycles[r0] > 2) begin
            n_fail++;
            $display("FAIL sread_ready: cmd_ready rose %0d cycles after handshake, expected 1..2",
                     rdy_rise.size() > q0 ? rdy_rise[q0] - hs_cycles[r0] : -1);
        end
    endtask

    task automatic test_write_burst();
        int b0 = beats.size();
        int r0 = resps.size();
        int w0 = windows.size();
        beat_t e;
        ack_dly = int'($urandom_range(1, 3));
        issue_cmd(1'b1, 32'h3000_0000, 32'h0000_0003, 4'hF, 4'd2, "wburst");
        wait_last(r0, 1, "wburst");
        n_cmp++;
        if (beats.size() - b0 != 3 || windows.size() - w0 != 3) begin
            n_fail++;
            $display("FAIL wburst_count: got %0d beats %0d windows, expected 3 and 3",
                     beats.size() - b0, windows.size() - w0);
        end
        for (int i = 0; i < 3; i++) begin
            e = mk_beat(32'h3000_0000 + 32'(4 * i), 1'b1, 32'h3, 4'hF);
            n_cmp++;
            if (beats[b0 + i] !== e) begin
                n_fail++;
                $display("FAIL wburst_beat%0d: got %h expected %h", i, beats[b0 + i], e);
            end
        end
        n_cmp++;
        if (resps.size() - r0 != 1 || resps[r0] !== mk_rsp(32'h0, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL wburst_rsp: got %0d rsps first %h, expected one %h",
                     resps.size() - r0, resps[r0], mk_rsp(32'h0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_backpressure();
        int r0 = resps.size();
        int s0 = stall_dats.size();
        int sb0 = stall_bus;
        ack_dly = 1;
        for (int i = 0; i < 4; i++) rd_seq[i] = 32'(i + 1);
        rd_base = rd_cnt;
        rd_mode = 1'b1;
        stall_at = r0 + 1;
        stall_until = stall_taken + 5;
        issue_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 4'd3, "bp");
        wait_last(r0, 1, "bp");
        rd_mode = 1'b0;
        stall_at = -1;
        n_cmp++;
        if (resps.size() - r0 != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d rsps, expected 4", resps.size() - r0);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (resps[r0 + i] !== mk_rsp(32'(i + 1), 1'b0, i == 3)) begin
                n_fail++;
                $display("FAIL bp_rsp%0d: got %h expected %h", i, resps[r0 + i], mk_rsp(32'(i + 1), 1'b0, i == 3));
            end
        end
        n_cmp++;
        if (stall_dats.size() - s0 != 5 || stall_bus != sb0) begin
            n_fail++;
            $display("FAIL bp_stall: got %0d stall cycles, %0d with cyc, expected 5 and 0",
                     stall_dats.size() - s0, stall_bus - sb0);
        end
        for (int i = s0; i < stall_dats.size(); i++) begin
            n_cmp++;
            if (stall_dats[i] !== 32'h2) begin
                n_fail++;
                $display("FAIL bp_hold: got rsp_dat %h during stall, expected 00000002", stall_dats[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int b0 = beats.size();
        int r0 = resps.size();
        int w0 = windows.size();
        no_ack = 1'b1;
        issue_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 4'd3, "tmo");
        wait_last(r0, 1, "tmo");
        repeat (20) @(negedge clk);
        no_ack = 1'b0;
        n_cmp++;
        if (windows.size() - w0 != 1 || windows[w0] != 8) begin
            n_fail++;
            $display("FAIL tmo_window: got %0d windows first len %0d, expected 1 window of 8",
                     windows.size() - w0, windows[w0]);
        end
        n_cmp++;
        if (resps.size() - r0 != 1 || resps[r0] !== mk_rsp(32'h0, 1'b1, 1'b1) || beats.size() != b0) begin
            n_fail++;
            $display("FAIL tmo_rsp: got %0d rsps first %h beats %0d, expected one %h and 0 beats",
                     resps.size() - r0, resps[r0], beats.size() - b0, mk_rsp(32'h0, 1'b1, 1'b1));
        end
    endtask

    task automatic test_reset_mid_beat();
        int r0 = resps.size();
        bit seen = 1'b0;
        no_ack = 1'b1;
        issue_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF, 4'd1, "rmid");
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cyc) seen = 1'b1;
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (!seen || {cyc, stb} !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_drop: seen=%b got cyc/stb=%b right after reset, expected 00", seen, {cyc, stb});
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        no_ack = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (resps.size() != r0 || {cmd_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmid_norsp: got %0d rsps rdy/busy=%b, expected 0 rsps and 10",
                     resps.size() - r0, {cmd_ready, busy});
        end
        ack_dly = 2;
        issue_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 4'd0, "rmid2");
        wait_last(r0, 1, "rmid2");
        n_cmp++;
        if (resps.size() - r0 != 1 || resps[r0] !== mk_rsp(slv_data(32'h3000_0008), 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL rmid_after: got %0d rsps first %h, expected one %h", resps.size() - r0,
                     resps[r0], mk_rsp(slv_data(32'h3000_0008), 1'b0, 1'b1));
        end
    endtask

    task automatic test_cmd_while_busy();
        int b0 = beats.size();
        int r0 = resps.size();
        int a0 = acc_cycles.size();
        bit ok = 1'b0;
        logic [31:0] ea [3];
        ea[0] = 32'h3000_0040; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0000_0000;
        ack_dly = 3;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = ea[0]; cmd_dat = 32'h0; cmd_sel = 4'hF; cmd_len = 4'd0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); #1;
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        cmd_adr = ea[1]; cmd_len = 4'd1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            if (acc_cycles.size() > a0 + 1) ok = 1'b1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_last(r0, 2, "busy");
        n_cmp++;
        if (!ok || acc_cycles[a0 + 1] != hs_cycles[r0] + 1) begin
            n_fail++;
            $display("FAIL busy_accept: second accept %0d cycles after first handshake, expected 1",
                     acc_cycles[a0 + 1] - hs_cycles[r0]);
        end
        n_cmp++;
        if (beats.size() - b0 != 3 || resps.size() - r0 != 3) begin
            n_fail++;
            $display("FAIL busy_count: got %0d beats %0d rsps, expected 3 and 3",
                     beats.size() - b0, resps.size() - r0);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (beats[b0 + i].adr !== ea[i] ||
                resps[r0 + i] !== mk_rsp(slv_data(ea[i]), 1'b0, i != 1)) begin
                n_fail++;
                $display("FAIL busy_beat%0d: got adr %h rsp %h, expected adr %h rsp %h", i,
                         beats[b0 + i].adr, resps[r0 + i], ea[i], mk_rsp(slv_data(ea[i]), 1'b0, i != 1));
            end
        end
    endtask

    task automatic test_random();
        logic        w;
        logic [31:0] a, d, ba;
        logic [3:0]  s, l;
        int          b0, r0, nexp;
        beat_t       eb;
        rsp_t        er;
        rr_random = 1'b1;
        for (int it = 0; it < 12; it++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : {$urandom, 2'b00} & 32'hFFFF_FFFC;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            l = 4'($urandom_range(0, 5));
            ack_dly = int'($urandom_range(1, 4));
            b0 = beats.size();
            r0 = resps.size();
            issue_cmd(w, a, d, s, l, "rand");
            wait_last(r0, 1, "rand");
            nexp = w ? 1 : int'(l) + 1;
            n_cmp++;
            if (beats.size() - b0 != int'(l) + 1 || resps.size() - r0 != nexp) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d beats %0d rsps, expected %0d and %0d", it,
                         beats.size() - b0, resps.size() - r0, int'(l) + 1, nexp);
            end
            for (int i = 0; i <= int'(l); i++) begin
                ba = a + 32'(4 * i);
                eb = mk_beat(ba, w, d, s);
                n_cmp++;
                if (beats[b0 + i] !== eb) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: got %h expected %h", it, i, beats[b0 + i], eb);
                end
                if (!w) begin
                    er = mk_rsp(slv_data(ba), 1'b0, i == int'(l));
                    n_cmp++;
                    if (resps[r0 + i] !== er) begin
                        n_fail++;
                        $display("FAIL rand%0d_rsp%0d: got %h expected %h", it, i, resps[r0 + i], er);
                    end
                end
            end
            if (w) begin
                n_cmp++;
                if (resps[r0] !== mk_rsp(32'h0, 1'b0, 1'b1)) begin
                    n_fail++;
                    $display("FAIL rand%0d_wrsp: got %h expected %h", it, resps[r0], mk_rsp(32'h0, 1'b0, 1'b1));
                end
            end
        end
        rr_random = 1'b0;
    endtask

    task automatic test_bus_invariants();
        n_cmp++;
        if (cs_bad != 0) begin
            n_fail++;
            $display("FAIL cyc_stb_equal: got %0d cycles with cyc != stb, expected 0", cs_bad);
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; cmd_len = '0;
        for (int i = 0; i < 4; i++) rd_seq[i] = '0;
        test_reset();
        test_single_read();
        test_write_burst();
        test_backpressure();
        test_timeout();
        test_reset_mid_beat();
        test_cmd_while_busy();
        test_random();
        test_bus_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
